// File: rtl/alu_loader_pkg.sv
// alu_loader_pkg: shared widths and FSM state encoding for the ALU operand loader
package alu_loader_pkg;

    localparam int WORD_W = 32;
    localparam int HALF_W = 16;
    localparam int OP_W   = 4;

    typedef enum logic [2:0] {
        A_LO  = 3'd0,
        A_HI  = 3'd1,
        B_LO  = 3'd2,
        B_HI  = 3'd3,
        OP    = 3'd4,
        VALID = 3'd5
    } state_t;

endpackage

// File: rtl/key_debounce.sv
// key_debounce: debounces one synchronized active-low key and strobes on an accepted press
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic CLOCK_50,
    input  logic RST,
    input  logic key_sync,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] cnt;
    logic          accept;

    assign accept = (key_sync != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));

    // Count consecutive samples differing from the accepted level; accept on the Nth
    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            cnt   <= (key_sync == level || accept) ? '0 : cnt + 1'b1;
            level <= accept ? key_sync : level;
            press <= accept && !key_sync;
        end
    end

endmodule

// File: rtl/alu_operand_loader.sv
// alu_operand_loader: keys/switches to 32-bit operands and opcode; ALU_LOADER_SIGNEXT_EN selects sign-extended 16-bit entry
module alu_operand_loader
    import alu_loader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic              CLOCK_50,
    input  logic              RST,
    input  logic [3:0]        KEY,
    input  logic [17:0]       SW,
    output logic [WORD_W-1:0] port_a,
    output logic [WORD_W-1:0] port_b,
    output logic [OP_W-1:0]   alu_op,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [17:0]       LEDR
);

    logic [3:0]        key_s1, key_s2;
    logic [17:0]       sw_s1, sw_s2;
    logic              enter_level, enter_press;
    logic              clear_level, clear_press;
    logic              unused_bits;
    logic [HALF_W-1:0] sw_d;
    state_t            state, state_nx;
    logic [WORD_W-1:0] a_nx, b_nx;
    logic [OP_W-1:0]   op_nx;

    // Two-flop synchronizers; reset to the released levels
    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            key_s1 <= 4'hF;
            key_s2 <= 4'hF;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            key_s1 <= KEY;
            key_s2 <= key_s1;
            sw_s1  <= SW;
            sw_s2  <= sw_s1;
        end
    end

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
        .CLOCK_50 (CLOCK_50),
        .RST      (RST),
        .key_sync (key_s2[0]),
        .level    (enter_level),
        .press    (enter_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .CLOCK_50 (CLOCK_50),
        .RST      (RST),
        .key_sync (key_s2[1]),
        .level    (clear_level),
        .press    (clear_press)
    );

    assign unused_bits = ^{key_s2[3:2], sw_s2[17:16], enter_level, clear_level};
    assign sw_d        = sw_s2[HALF_W-1:0];

    // Next state and next operand values; clear overrides everything else
    always_comb begin
        state_nx = state;
        a_nx     = port_a;
        b_nx     = port_b;
        op_nx    = alu_op;
        if (clear_press) begin
            state_nx = A_LO;
            a_nx     = '0;
            b_nx     = '0;
            op_nx    = '0;
        end else begin
            case (state)
                A_LO: if (enter_press) begin
`ifdef ALU_LOADER_SIGNEXT_EN
                    a_nx     = {{HALF_W{sw_d[HALF_W-1]}}, sw_d};
                    state_nx = B_LO;
`else
                    a_nx[HALF_W-1:0] = sw_d;
                    state_nx         = A_HI;
`endif
                end
                A_HI: if (enter_press) begin
                    a_nx[WORD_W-1:HALF_W] = sw_d;
                    state_nx              = B_LO;
                end
                B_LO: if (enter_press) begin
`ifdef ALU_LOADER_SIGNEXT_EN
                    b_nx     = {{HALF_W{sw_d[HALF_W-1]}}, sw_d};
                    state_nx = OP;
`else
                    b_nx[HALF_W-1:0] = sw_d;
                    state_nx         = B_HI;
`endif
                end
                B_HI: if (enter_press) begin
                    b_nx[WORD_W-1:HALF_W] = sw_d;
                    state_nx              = OP;
                end
                OP: if (enter_press) begin
                    op_nx    = sw_d[OP_W-1:0];
                    state_nx = VALID;
                end
                VALID: if (op_valid && op_ready) state_nx = A_LO;
                default: state_nx = A_LO;
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            state    <= A_LO;
            port_a   <= '0;
            port_b   <= '0;
            alu_op   <= '0;
            op_valid <= 1'b0;
        end else begin
            state    <= state_nx;
            port_a   <= a_nx;
            port_b   <= b_nx;
            alu_op   <= op_nx;
            op_valid <= (state_nx == VALID);
        end
    end

    assign LEDR = {op_valid, 14'd0, state};

endmodule

// File: tb/tb_alu_operand_loader.sv
// tb_alu_operand_loader: directed bench with an operand scoreboard; build with ALU_LOADER_SIGNEXT_EN for the sign-extend variant
module tb_alu_operand_loader;
    import alu_loader_pkg::*;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
    } exp_t;

`ifdef ALU_LOADER_SIGNEXT_EN
    localparam logic [2:0] FIRST_NX = 3'd2;
`else
    localparam logic [2:0] FIRST_NX = 3'd1;
`endif

    logic        CLOCK_50;
    logic        RST;
    logic [3:0]  KEY;
    logic [17:0] SW;
    logic [31:0] port_a, port_b;
    logic [3:0]  alu_op;
    logic        op_valid;
    logic        op_ready;
    logic [17:0] LEDR;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   seen_hi = 0;

    alu_operand_loader #(.DEBOUNCE_CYCLES(4)) dut (
        .CLOCK_50 (CLOCK_50),
        .RST      (RST),
        .KEY      (KEY),
        .SW       (SW),
        .port_a   (port_a),
        .port_b   (port_b),
        .alu_op   (alu_op),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .LEDR     (LEDR)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    // Record whether an upper-half entry state ever shows on the LEDs
    always @(negedge CLOCK_50) if (LEDR[2:0] == 3'd1 || LEDR[2:0] == 3'd3) seen_hi = 1'b1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic press(input logic [3:0] mask);
        KEY = KEY & ~mask;
        tick(10);
        KEY = 4'hF;
        tick(10);
    endtask

    task automatic enter(input logic [15:0] v);
        SW = {2'b11, v};
        press(4'b0001);
    endtask

    task automatic run_op(input logic [15:0] a_lo, a_hi, b_lo, b_hi, input logic [3:0] op);
        exp_t e;
`ifdef ALU_LOADER_SIGNEXT_EN
        e.a = {{16{a_lo[15]}}, a_lo};
        e.b = {{16{b_lo[15]}}, b_lo};
        enter(a_lo);
        enter(b_lo);
`else
        e.a = {a_hi, a_lo};
        e.b = {b_hi, b_lo};
        enter(a_lo);
        enter(a_hi);
        enter(b_lo);
        enter(b_hi);
`endif
        e.op = op;
        sb.push_back(e);
        enter({12'hABC, op});
    endtask

    task automatic check_valid(input string tag);
        exp_t e;
        int   k = 0;
        while (!op_valid && k < 20) begin
            tick(1);
            k++;
        end
        chk({tag, "_valid"}, {31'd0, op_valid}, 32'd1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_port_a"}, port_a, e.a);
            chk({tag, "_port_b"}, port_b, e.b);
            chk({tag, "_alu_op"}, {28'd0, alu_op}, {28'd0, e.op});
        end
    endtask

    initial begin
        KEY = 4'hF;
        SW = '0;
        op_ready = 1'b0;
        RST = 1'b1;
        tick(3);
        RST = 1'b0;
        tick(1);
        chk("rst_port_a", port_a, 32'd0);
        chk("rst_port_b", port_b, 32'd0);
        chk("rst_alu_op", {28'd0, alu_op}, 32'd0);
        chk("rst_op_valid", {31'd0, op_valid}, 32'd0);
        chk("rst_ledr", {14'd0, LEDR}, 32'd0);

        // Bounce: low 2, high 1, low 6 must give exactly one enter
        SW = {2'b11, 16'h1234};
        KEY[0] = 1'b0;
        tick(2);
        KEY[0] = 1'b1;
        tick(1);
        KEY[0] = 1'b0;
        tick(5);
        chk("bounce_early", {29'd0, LEDR[2:0]}, 32'd0);
        tick(1);
        KEY[0] = 1'b1;
        tick(1);
        chk("bounce_accept", {29'd0, LEDR[2:0]}, {29'd0, FIRST_NX});
        chk("bounce_port_a", port_a, 32'h0000_1234);
        tick(12);
        chk("bounce_release", {29'd0, LEDR[2:0]}, {29'd0, FIRST_NX});
        press(4'b0010);
        chk("clear_state", {29'd0, LEDR[2:0]}, 32'd0);
        chk("clear_port_a", port_a, 32'd0);

`ifndef ALU_LOADER_SIGNEXT_EN
        enter(16'h1111);
        enter(16'h2222);
        chk("mid_port_a", port_a, 32'h2222_1111);
        chk("mid_state", {29'd0, LEDR[2:0]}, 32'd2);
        press(4'b0010);
        chk("mid_clr_port_a", port_a, 32'd0);
        chk("mid_clr_state", {29'd0, LEDR[2:0]}, 32'd0);
        enter(16'h5555);
        chk("pre_both_state", {29'd0, LEDR[2:0]}, 32'd1);
        SW = {2'b00, 16'h7777};
        press(4'b0011);
        chk("both_state", {29'd0, LEDR[2:0]}, 32'd0);
        chk("both_port_a", port_a, 32'd0);

        run_op(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 4'h3);
        check_valid("full");
        chk("full_state", {29'd0, LEDR[2:0]}, 32'd5);
        chk("full_ledr17", {31'd0, LEDR[17]}, 32'd1);
        enter(16'hAAAA);
        chk("valid_enter_state", {29'd0, LEDR[2:0]}, 32'd5);
        chk("valid_enter_port_a", port_a, 32'h5678_1234);
        for (int i = 0; i < 10; i++) begin
            chk("hold_valid", {31'd0, op_valid}, 32'd1);
            tick(1);
        end
        op_ready = 1'b1;
        chk("ready_cycle_valid", {31'd0, op_valid}, 32'd1);
        tick(1);
        op_ready = 1'b0;
        chk("post_hs_valid", {31'd0, op_valid}, 32'd0);
        chk("post_hs_state", {29'd0, LEDR[2:0]}, 32'd0);
        chk("post_hs_port_a", port_a, 32'h5678_1234);
        chk("post_hs_port_b", port_b, 32'hDEF0_9ABC);
        chk("post_hs_alu_op", {28'd0, alu_op}, 32'd3);
`else
        enter(16'h8001);
        chk("sext_a_state", {29'd0, LEDR[2:0]}, 32'd2);
        chk("sext_a", port_a, 32'hFFFF_8001);
        enter(16'h0002);
        chk("sext_b_state", {29'd0, LEDR[2:0]}, 32'd4);
        chk("sext_b", port_b, 32'h0000_0002);
        sb.push_back('{a: 32'hFFFF_8001, b: 32'h0000_0002, op: 4'h1});
        enter(16'h0001);
        check_valid("sext");
        op_ready = 1'b1;
        tick(1);
        op_ready = 1'b0;
        chk("sext_post_hs_valid", {31'd0, op_valid}, 32'd0);
        chk("sext_post_hs_port_a", port_a, 32'hFFFF_8001);
`endif

        // Clear strobe lands in the same cycle as op_ready
        run_op(16'h0001, 16'h0002, 16'h0003, 16'h0004, 4'h5);
        check_valid("second");
        KEY[1] = 1'b0;
        tick(6);
        chk("clr_rdy_pre_valid", {31'd0, op_valid}, 32'd1);
        chk("clr_rdy_pre_state", {29'd0, LEDR[2:0]}, 32'd5);
        op_ready = 1'b1;
        tick(1);
        op_ready = 1'b0;
        chk("clr_rdy_state", {29'd0, LEDR[2:0]}, 32'd0);
        chk("clr_rdy_port_a", port_a, 32'd0);
        chk("clr_rdy_port_b", port_b, 32'd0);
        chk("clr_rdy_alu_op", {28'd0, alu_op}, 32'd0);
        chk("clr_rdy_valid", {31'd0, op_valid}, 32'd0);
        KEY = 4'hF;
        tick(10);

        // Reset while an operation is pending
        run_op(16'hBEEF, 16'hCAFE, 16'h0F0F, 16'hF0F0, 4'hA);
        check_valid("third");
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        chk("rst_valid_port_a", port_a, 32'd0);
        chk("rst_valid_port_b", port_b, 32'd0);
        chk("rst_valid_alu_op", {28'd0, alu_op}, 32'd0);
        chk("rst_valid_op_valid", {31'd0, op_valid}, 32'd0);
        chk("rst_valid_ledr", {14'd0, LEDR}, 32'd0);
        tick(10);
        chk("rst_quiet_state", {29'd0, LEDR[2:0]}, 32'd0);
        chk("rst_quiet_port_a", port_a, 32'd0);

`ifdef ALU_LOADER_SIGNEXT_EN
        chk("sext_no_hi_states", {31'd0, seen_hi}, 32'd0);
`endif
        chk("sb_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_operand_loader.md
ALU_OPERAND_LOADER -- requirements
Module: alu_operand_loader

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000: stable-input cycles before a key change is accepted (5 ms at 50 MHz).
REQ-002 CLOCK_50  input  1  sole clock; all state updates on posedge.
REQ-003 RST  input  1  synchronous, active-high reset.
REQ-004 KEY  input  4  raw push buttons, active-low, asynchronous; KEY[0]=enter, KEY[1]=clear, KEY[3:2] unused.
REQ-005 SW  input  18  raw slide switches, asynchronous; SW[15:0] data entry.
REQ-006 port_a  output  32  assembled operand A.
REQ-007 port_b  output  32  assembled operand B.
REQ-008 alu_op  output  4  captured ALU opcode.
REQ-009 op_valid  output  1  port_a/port_b/alu_op complete and stable.
REQ-010 op_ready  input  1  consumer accepts the operation.
REQ-011 LEDR  output  18  LEDR[2:0]=state code, LEDR[17]=op_valid, LEDR[16:3]=0.

Function
REQ-012 KEY and SW each pass through a 2-flop synchronizer before any use.
REQ-013 Each synchronized KEY bit is debounced: accepted level changes only after DEBOUNCE_CYCLES consecutive identical samples; counter restarts on any mismatch.
REQ-014 Press pulse = one-cycle strobe on accepted high-to-low transition of a debounced KEY; no strobe on release.
REQ-015 FSM states/codes: A_LO=0, A_HI=1, B_LO=2, B_HI=3, OP=4, VALID=5.
REQ-016 Enter strobe in A_LO/A_HI/B_LO/B_HI writes SW[15:0] into port_a[15:0]/port_a[31:16]/port_b[15:0]/port_b[31:16] respectively and advances one state.
REQ-017 Enter strobe in OP writes SW[3:0] into alu_op and advances to VALID.
REQ-018 VALID: op_valid=1; held until cycle with op_valid&&op_ready, then next state A_LO; port_a, port_b, alu_op hold their values.
REQ-019 op_valid is 0 in every state except VALID; op_ready outside VALID is ignored.
REQ-020 Enter strobe in VALID is ignored.
REQ-021 Clear strobe in any state: next state A_LO, port_a, port_b, alu_op cleared to 0.
REQ-022 Clear and enter strobes in the same cycle: clear wins, enter discarded.
REQ-023 Clear strobe coinciding with op_ready in VALID: clear wins; the handshake still counts as completed by the consumer (op_valid was 1 that cycle).
REQ-024 Outputs registered; capture visible the cycle after the strobe.

Reset
REQ-025 RST high: state A_LO, port_a=0, port_b=0, alu_op=0, op_valid=0, LEDR=0.
REQ-026 RST high: synchronizers cleared to released (key=1, switch=0), debounced levels=1, debounce counters=0, no strobes for the following DEBOUNCE_CYCLES.
REQ-027 RST asserted mid-entry or in VALID discards the partial/pending operation identically to REQ-025.

Configuration
REQ-028 Macro ALU_LOADER_SIGNEXT_EN defined: A_HI and B_HI never entered; A_LO enter writes port_a={{16{SW[15]}},SW[15:0]} and goes to B_LO; B_LO likewise for port_b then OP.
REQ-029 Macro undefined: full four-half entry per REQ-016, no sign extension.

Structure
REQ-030 Package alu_loader_pkg holds the state enum (3-bit, codes per REQ-015), WORD_W=32, HALF_W=16, OP_W=4.
REQ-031 Sub-module key_debounce (synchronized bit in, debounced level and press strobe out, DEBOUNCE_CYCLES parameter), instantiated once per used KEY bit.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-032 Bounce: KEY[0] low 2 cycles, high 1, low 6 -> exactly one enter strobe, 4 stable cycles after final low.
REQ-033 Full entry, macro off: SW=0x1234,0x5678,0x9ABC,0xDEF0,0x3 entered -> port_a=0x56781234, port_b=0xDEF09ABC, alu_op=0x3, op_valid=1, LEDR[2:0]=5.
REQ-034 Handshake: op_ready held 0 for 10 cycles then 1 -> op_valid stays 1 until the ready cycle, 0 next cycle, state A_LO, operands held.
REQ-035 Clear mid-entry: after A_LO/A_HI captures, press KEY[1] -> port_a=0, state A_LO; simultaneous enter+clear -> clear result only.
REQ-036 Macro on: SW=0x8001 into A, 0x0002 into B, op 0x1 -> port_a=0xFFFF8001, port_b=0x00000002, states A_HI/B_HI never observed.
REQ-037 RST pulsed while in VALID -> all outputs 0, state A_LO next cycle, no spurious strobe.
